uart_phy: RTL and testbench
===========================

// Module: uart_phy
// PURPOSE
//  Byte-level UART serialiser/deserialiser with TX/RX FIFOs; sits directly downstream of the
//  NASTI-Lite UART register slave on the IO bus, and drives/samples the chip txd/rxd pins.
//  Register slave pushes TX bytes, pops RX bytes and reads/clears sticky error flags.
// PARAMETERS
//  CLK_FREQ    100000000  input clock frequency, Hz
//  BAUD        115200     line rate; DIV = CLK_FREQ/(BAUD*16) (integer truncation, must be >=1)
//  FIFO_DEPTH  16         entries per TX and RX FIFO, power of two, >=2
//  PARITY      0          0 none, 1 odd, 2 even
//  STOP_BITS   1          1 or 2
// PORTS
//  clk         in   1  system clock
//  rst         in   1  asynchronous, active-high reset
//  tx_data     in   8  byte to transmit
//  tx_valid    in   1  push request; accepted when tx_valid & tx_ready
//  tx_ready    out  1  TX FIFO not full
//  rx_data     out  8  head of RX FIFO
//  rx_valid    out  1  RX FIFO not empty
//  rx_ready    in   1  pop; takes effect when rx_valid & rx_ready
//  err_clr     in   1  one-cycle pulse clears all sticky error flags
//  tx_idle     out  1  TX FIFO empty and TX FSM in IDLE
//  rx_overrun  out  1  sticky: received byte dropped because RX FIFO full
//  parity_err  out  1  sticky: parity mismatch on a received byte
//  frame_err   out  1  sticky: stop bit sampled low
//  rxd         in   1  serial input (asynchronous)
//  txd         out  1  serial output, idle high
// BEHAVIOUR
//  Reset (async, any time incl. mid-frame): txd=1, tx_ready=1, rx_valid=0, tx_idle=1, all
//   error flags 0, both FIFOs flushed, both FSMs IDLE, rxd synchroniser flops preset to 1.
//  Bit period = 16*DIV clocks; TX and RX each own a tick counter restarted at frame start.
//  TX FSM IDLE->START->DATA(8 bits, LSB first)->[PARITY]->STOP(STOP_BITS)->IDLE.
//   IDLE pops FIFO when non-empty; txd falls the cycle after the pop; pop occurs the cycle
//   after a push into an empty FIFO, so start bit begins 2 clocks after the push handshake.
//   At end of STOP, if FIFO non-empty go straight to START (back-to-back, no idle gap).
//  RX: rxd through 2-flop synchroniser; IDLE detects 1->0 on synchronised rxd.
//   START: sample at 8*DIV clocks; if high -> false start, back to IDLE, nothing pushed.
//   DATA/PARITY/STOP: sample each bit at its centre (every 16*DIV clocks after start centre).
//   Parity mismatch: byte still pushed, parity_err set. Stop bit low: byte discarded,
//   frame_err set, FSM waits for rxd high before re-arming IDLE (break handling).
//   Only first stop bit checked on RX when STOP_BITS=2.
//  RX push at end of STOP: if FIFO full and no pop that cycle -> drop byte, set rx_overrun.
//   Pop and push in the same cycle on a full FIFO both succeed; no overrun.
//  Sticky flags: set has priority over err_clr in the same cycle.
//  FIFOs: first-word-fall-through; rx_data valid combinationally with rx_valid; pointer
//   width $clog2(FIFO_DEPTH)+1 for full/empty disambiguation, wraps naturally.
//  tx_valid while tx_ready=0: ignored, no state change.
// STRUCTURE
//  uart_pkg: tx/rx state enums, parity encoding constants (PAR_NONE/ODD/EVEN), DIV function.
//  Sub-module uart_fifo (sync FWFT FIFO, params WIDTH, DEPTH), instantiated twice (TX, RX).
//  TX FSM, RX FSM, synchroniser and error flags live in uart_phy.
// TESTING  (bench params CLK_FREQ=1600000, BAUD=100000 -> DIV=1, 16 clocks/bit)
//  Push 0xA5 while idle -> txd low at handshake+2 clocks, then 1,0,1,0,0,1,0,1, stop high;
//   frame 160 clocks; tx_idle returns 1.
//  Drive rxd frame 0x3C (8N1, 16 clocks/bit) -> rx_valid 1 with rx_data 0x3C within
//   2 clocks of stop-bit centre + sync delay; no error flags.
//  PARITY=2: send 0x07 with parity bit 0 -> byte pushed, parity_err=1; err_clr -> 0.
//  Fill RX FIFO with 16 frames, rx_ready=0, send 17th -> rx_overrun=1, FIFO holds first 16;
//   repeat with rx_ready pulsed on push cycle -> no overrun.
//  rxd low pulse of 4 clocks -> false start, no push; frame with stop bit 0 -> frame_err=1,
//   nothing pushed.
//  Push 3 bytes, assert rst mid-second-byte -> txd=1 immediately, tx_idle=1, nothing else sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART PHY: FSM state encodings, parity
// mode constants and the baud divisor calculation.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    // Clocks per 1/16 bit; integer truncation, caller guarantees result >= 1.
    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / (baud * 16);
    endfunction

    // Parity bit that accompanies a byte for the given mode (even when not odd).
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        return (mode == PAR_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_phy_if.sv
// Byte-side handshake between the UART register slave (master) and the PHY (slave).
interface uart_phy_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       err_clr;
    logic       tx_idle;
    logic       rx_overrun;
    logic       parity_err;
    logic       frame_err;

    modport master (
        output tx_data, tx_valid, rx_ready, err_clr,
        input  tx_ready, rx_data, rx_valid, tx_idle, rx_overrun, parity_err, frame_err
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready, err_clr,
        output tx_ready, rx_data, rx_valid, tx_idle, rx_overrun, parity_err, frame_err
    );

endinterface

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO. A write into a full FIFO is
// accepted only when a read happens in the same cycle.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; reset flushes the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_phy.sv
// UART serialiser/deserialiser with TX/RX FIFOs, rxd synchroniser and
// sticky error flags.
//
// TX FSM
//   state     | meaning
//   TX_IDLE   | line idle, pops FIFO when a byte is waiting
//   TX_START  | driving start bit (0)
//   TX_DATA   | driving data bits, LSB first
//   TX_PARITY | driving parity bit (only when PARITY != none)
//   TX_STOP   | driving stop bit(s); chains straight to START if FIFO non-empty
//
// RX FSM
//   state     | meaning
//   RX_IDLE   | waiting for falling edge on synchronised rxd
//   RX_START  | half-bit wait, confirm start bit still low
//   RX_DATA   | sampling data bits at bit centres
//   RX_PARITY | sampling and checking parity bit
//   RX_STOP   | sampling first stop bit, push or flag framing error
//   RX_BREAK  | after framing error, wait for line high before re-arming
module uart_phy
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    uart_phy_if.slave  bus,
    input  logic       rxd,
    output logic       txd
);

    localparam int DIV = baud_div(CLK_FREQ, BAUD);
    localparam int TW  = $clog2(16 * DIV) + 1;
    localparam logic [TW-1:0] BIT_LAST  = TW'(16 * DIV - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(8 * DIV - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    // ---------------- TX ----------------
    tx_state_t   tx_state, tx_state_n;
    logic [TW-1:0] tx_tick, tx_tick_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_byte, tx_byte_n;
    logic        tx_tc;
    logic        tx_pop;
    logic        txd_n;
    logic        tx_full, tx_empty;
    logic [7:0]  tx_head;

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.tx_valid && !tx_full),
        .wr_data (bus.tx_data),
        .rd_en   (tx_pop),
        .rd_data (tx_head),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    assign tx_tc       = (tx_tick == '0);
    assign bus.tx_ready = !tx_full;
    assign bus.tx_idle  = tx_empty && (tx_state == TX_IDLE);

    // TX next-state, bit timing and line level; txd is registered so it trails state by one clock.
    always_comb begin
        tx_state_n = tx_state;
        tx_tick_n  = tx_tick;
        tx_bit_n   = tx_bit;
        tx_byte_n  = tx_byte;
        tx_pop     = 1'b0;
        txd_n      = 1'b1;
        if (!tx_tc) tx_tick_n = tx_tick - 1'b1;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_byte_n  = tx_head;
                    tx_tick_n  = BIT_LAST;
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                txd_n = 1'b0;
                if (tx_tc) begin
                    tx_tick_n  = BIT_LAST;
                    tx_bit_n   = '0;
                    tx_state_n = TX_DATA;
                end
            end
            TX_DATA: begin
                txd_n = tx_byte[tx_bit];
                if (tx_tc) begin
                    tx_tick_n = BIT_LAST;
                    if (tx_bit == 3'd7) begin
                        tx_bit_n   = '0;
                        tx_state_n = (PARITY != PAR_NONE) ? TX_PARITY : TX_STOP;
                    end else begin
                        tx_bit_n = tx_bit + 1'b1;
                    end
                end
            end
            TX_PARITY: begin
                txd_n = parity_bit(tx_byte, PARITY);
                if (tx_tc) begin
                    tx_tick_n  = BIT_LAST;
                    tx_bit_n   = '0;
                    tx_state_n = TX_STOP;
                end
            end
            TX_STOP: begin
                txd_n = 1'b1;
                if (tx_tc) begin
                    if (tx_bit == STOP_LAST) begin
                        tx_bit_n = '0;
                        if (!tx_empty) begin
                            tx_pop     = 1'b1;
                            tx_byte_n  = tx_head;
                            tx_tick_n  = BIT_LAST;
                            tx_state_n = TX_START;
                        end else begin
                            tx_state_n = TX_IDLE;
                        end
                    end else begin
                        tx_tick_n = BIT_LAST;
                        tx_bit_n  = tx_bit + 1'b1;
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    // TX state register and line driver; line idles high through reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_tick  <= '0;
            tx_bit   <= '0;
            tx_byte  <= '0;
            txd      <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_tick  <= tx_tick_n;
            tx_bit   <= tx_bit_n;
            tx_byte  <= tx_byte_n;
            txd      <= txd_n;
        end
    end

    // ---------------- RX ----------------
    logic        rxd_s1, rxd_s2, rxd_q;
    logic        rx_fall;
    rx_state_t   rx_state, rx_state_n;
    logic [TW-1:0] rx_tick, rx_tick_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_byte, rx_byte_n;
    logic        rx_tc;
    logic        rx_push;
    logic        rx_pop;
    logic        rx_full, rx_empty;
    logic        par_set, frame_set, ovr_set;
    logic        rx_overrun_q, parity_err_q, frame_err_q;

    // rxd synchroniser plus one history flop for edge detection; all idle high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_q  <= 1'b1;
        end else begin
            rxd_s1 <= rxd;
            rxd_s2 <= rxd_s1;
            rxd_q  <= rxd_s2;
        end
    end

    assign rx_fall = rxd_q && !rxd_s2;
    assign rx_tc   = (rx_tick == '0);

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (rx_push),
        .wr_data (rx_byte),
        .rd_en   (bus.rx_ready),
        .rd_data (bus.rx_data),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    assign bus.rx_valid = !rx_empty;
    assign rx_pop       = !rx_empty && bus.rx_ready;
    assign ovr_set      = rx_push && rx_full && !rx_pop;

    // RX next-state and bit-centre sampling; the byte is pushed on a good stop bit.
    always_comb begin
        rx_state_n = rx_state;
        rx_tick_n  = rx_tick;
        rx_bit_n   = rx_bit;
        rx_byte_n  = rx_byte;
        rx_push    = 1'b0;
        par_set    = 1'b0;
        frame_set  = 1'b0;
        if (!rx_tc) rx_tick_n = rx_tick - 1'b1;
        case (rx_state)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_tick_n  = HALF_LAST;
                    rx_state_n = RX_START;
                end
            end
            RX_START: begin
                if (rx_tc) begin
                    if (rxd_s2) begin
                        rx_state_n = RX_IDLE;
                    end else begin
                        rx_tick_n  = BIT_LAST;
                        rx_bit_n   = '0;
                        rx_state_n = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (rx_tc) begin
                    rx_tick_n = BIT_LAST;
                    rx_byte_n = {rxd_s2, rx_byte[7:1]};
                    if (rx_bit == 3'd7) begin
                        rx_bit_n   = '0;
                        rx_state_n = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_n = rx_bit + 1'b1;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_tc) begin
                    rx_tick_n  = BIT_LAST;
                    par_set    = (rxd_s2 != parity_bit(rx_byte, PARITY));
                    rx_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_tc) begin
                    if (rxd_s2) begin
                        rx_push    = 1'b1;
                        rx_state_n = RX_IDLE;
                    end else begin
                        frame_set  = 1'b1;
                        rx_state_n = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                if (rxd_s2) rx_state_n = RX_IDLE;
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // RX state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_tick  <= '0;
            rx_bit   <= '0;
            rx_byte  <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_tick  <= rx_tick_n;
            rx_bit   <= rx_bit_n;
            rx_byte  <= rx_byte_n;
        end
    end

    // Sticky error flags; a new error in the clear cycle wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_overrun_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_overrun_q <= ovr_set   || (rx_overrun_q && !bus.err_clr);
            parity_err_q <= par_set   || (parity_err_q && !bus.err_clr);
            frame_err_q  <= frame_set || (frame_err_q  && !bus.err_clr);
        end
    end

    assign bus.rx_overrun = rx_overrun_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_phy.sv
// Directed bench for uart_phy: one 8N1 instance and one 8E1 instance, 16 clocks per bit.
module tb_uart_phy;

    logic clk;
    logic rst;
    logic rxd_a, txd_a;
    logic rxd_b, txd_b;
    int   n_vec;
    int   n_miss;

    uart_phy_if bus_a ();
    uart_phy_if bus_b ();

    uart_phy #(
        .CLK_FREQ(1600000), .BAUD(100000), .FIFO_DEPTH(16), .PARITY(0), .STOP_BITS(1)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_a),
        .rxd (rxd_a),
        .txd (txd_a)
    );

    uart_phy #(
        .CLK_FREQ(1600000), .BAUD(100000), .FIFO_DEPTH(16), .PARITY(2), .STOP_BITS(1)
    ) u_par (
        .clk (clk),
        .rst (rst),
        .bus (bus_b),
        .rxd (rxd_b),
        .txd (txd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_rxd(input bit sel, input logic v);
        if (sel) rxd_b = v;
        else     rxd_a = v;
    endtask

    task automatic bit_time();
        repeat (16) @(posedge clk);
        #1;
    endtask

    // Serial frame onto rxd of the selected instance; line left high afterwards.
    task automatic send_rx(input bit sel, input logic [7:0] b, input bit has_par,
                           input logic par, input logic stop);
        set_rxd(sel, 1'b0);
        bit_time();
        for (int i = 0; i < 8; i++) begin
            set_rxd(sel, b[i]);
            bit_time();
        end
        if (has_par) begin
            set_rxd(sel, par);
            bit_time();
        end
        set_rxd(sel, stop);
        bit_time();
        set_rxd(sel, 1'b1);
    endtask

    task automatic pop_a(input string tag, input logic [7:0] exp);
        chk(tag, bus_a.rx_data, exp);
        bus_a.rx_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_a.rx_ready = 1'b0;
    endtask

    task automatic clr_a();
        bus_a.err_clr = 1'b1;
        @(posedge clk);
        #1;
        bus_a.err_clr = 1'b0;
    endtask

    logic [7:0] pat;
    int         lows;

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst    = 1'b1;
        rxd_a  = 1'b1;
        rxd_b  = 1'b1;
        bus_a.tx_data = '0; bus_a.tx_valid = 1'b0; bus_a.rx_ready = 1'b0; bus_a.err_clr = 1'b0;
        bus_b.tx_data = '0; bus_b.tx_valid = 1'b0; bus_b.rx_ready = 1'b0; bus_b.err_clr = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // reset state
        chk("rst_txd", txd_a, 1'b1);
        chk("rst_tx_ready", bus_a.tx_ready, 1'b1);
        chk("rst_rx_valid", bus_a.rx_valid, 1'b0);
        chk("rst_tx_idle", bus_a.tx_idle, 1'b1);
        chk("rst_flags", {bus_a.rx_overrun, bus_a.parity_err, bus_a.frame_err}, 3'b000);
        chk("rst_par_txd", txd_b, 1'b1);

        // TX 0xA5: start bit two clocks after handshake, LSB first, 160-clock frame
        pat = 8'hA5;
        bus_a.tx_data  = pat;
        bus_a.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_a.tx_valid = 1'b0;
        chk("tx_busy", bus_a.tx_idle, 1'b0);
        @(posedge clk);
        #1;
        chk("tx_lat_h1", txd_a, 1'b1);
        @(posedge clk);
        #1;
        chk("tx_lat_h2", txd_a, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        chk("tx_start_mid", txd_a, 1'b0);
        for (int i = 0; i < 8; i++) begin
            bit_time();
            chk($sformatf("tx_a5_bit%0d", i), txd_a, pat[i]);
        end
        bit_time();
        chk("tx_stop", txd_a, 1'b1);
        chk("tx_idle_in_stop", bus_a.tx_idle, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        chk("tx_idle_after", bus_a.tx_idle, 1'b1);

        // RX 0x3C, 8N1
        send_rx(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
        chk("rx_3c_valid", bus_a.rx_valid, 1'b1);
        chk("rx_3c_flags", {bus_a.rx_overrun, bus_a.parity_err, bus_a.frame_err}, 3'b000);
        pop_a("rx_3c_data", 8'h3C);
        chk("rx_3c_empty", bus_a.rx_valid, 1'b0);

        // even parity instance: good parity then bad parity
        send_rx(1'b1, 8'h81, 1'b1, 1'b0, 1'b1);
        chk("par_81_valid", bus_b.rx_valid, 1'b1);
        chk("par_81_data", bus_b.rx_data, 8'h81);
        chk("par_81_err", bus_b.parity_err, 1'b0);
        bus_b.rx_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_b.rx_ready = 1'b0;
        send_rx(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
        chk("par_07_valid", bus_b.rx_valid, 1'b1);
        chk("par_07_data", bus_b.rx_data, 8'h07);
        chk("par_07_err", bus_b.parity_err, 1'b1);
        bus_b.err_clr = 1'b1;
        @(posedge clk);
        #1;
        bus_b.err_clr = 1'b0;
        chk("par_clr", bus_b.parity_err, 1'b0);

        // overrun: 16 frames fill RX FIFO, 17th dropped
        for (int i = 0; i < 16; i++) send_rx(1'b0, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b1);
        chk("ovr_full_no_flag", bus_a.rx_overrun, 1'b0);
        send_rx(1'b0, 8'hEE, 1'b0, 1'b0, 1'b1);
        chk("ovr_flag", bus_a.rx_overrun, 1'b1);
        for (int i = 0; i < 16; i++) pop_a($sformatf("ovr_data%0d", i), 8'h10 + 8'(i));
        chk("ovr_drained", bus_a.rx_valid, 1'b0);
        clr_a();
        chk("ovr_clr", bus_a.rx_overrun, 1'b0);

        // full FIFO with a pop on the push cycle: both succeed
        for (int i = 0; i < 16; i++) send_rx(1'b0, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b1);
        fork
            send_rx(1'b0, 8'h77, 1'b0, 1'b0, 1'b1);
            begin
                repeat (154) @(posedge clk);
                #1;
                bus_a.rx_ready = 1'b1;
                @(posedge clk);
                #1;
                bus_a.rx_ready = 1'b0;
            end
        join
        chk("pp_no_ovr", bus_a.rx_overrun, 1'b0);
        for (int i = 1; i < 16; i++) pop_a($sformatf("pp_data%0d", i), 8'h40 + 8'(i));
        pop_a("pp_data_new", 8'h77);
        chk("pp_drained", bus_a.rx_valid, 1'b0);

        // false start: 4-clock glitch
        set_rxd(1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        set_rxd(1'b0, 1'b1);
        repeat (40) @(posedge clk);
        #1;
        chk("fs_no_push", bus_a.rx_valid, 1'b0);
        chk("fs_no_ferr", bus_a.frame_err, 1'b0);

        // framing error: stop bit low
        send_rx(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("fe_flag", bus_a.frame_err, 1'b1);
        chk("fe_no_push", bus_a.rx_valid, 1'b0);
        clr_a();
        chk("fe_clr", bus_a.frame_err, 1'b0);
        send_rx(1'b0, 8'h96, 1'b0, 1'b0, 1'b1);
        chk("fe_rearm_valid", bus_a.rx_valid, 1'b1);
        pop_a("fe_rearm_data", 8'h96);

        // 3 bytes back-to-back, reset during the second
        bus_a.tx_data  = 8'h11;
        bus_a.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_a.tx_data = 8'h22;
        @(posedge clk);
        #1;
        bus_a.tx_data = 8'h33;
        @(posedge clk);
        #1;
        bus_a.tx_valid = 1'b0;
        repeat (152) @(posedge clk);
        #1;
        chk("b2b_stop1", txd_a, 1'b1);
        bit_time();
        chk("b2b_start2", txd_a, 1'b0);
        repeat (70) @(posedge clk);
        #1;
        chk("b2b_busy", bus_a.tx_idle, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_txd", txd_a, 1'b1);
        chk("mid_rst_idle", bus_a.tx_idle, 1'b1);
        chk("mid_rst_ready", bus_a.tx_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (txd_a !== 1'b1) lows++;
        end
        chk("post_rst_quiet", lows, 0);
        chk("post_rst_idle", bus_a.tx_idle, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
